// File: rtl/gray_pkg.sv
// Shared constants and Gray/binary conversion helpers for the Gray counter.
package gray_pkg;
  localparam int WIDTH_DEFAULT = 4;

  function automatic logic [15:0] bin2gray(input logic [15:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Ripple XOR from the MSB down; bit i is the parity of g[15:i].
  function automatic logic [15:0] gray2bin(input logic [15:0] g);
    logic [15:0] b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/bin2gray_comb.sv
// Purely combinational WIDTH-wide binary-to-Gray encoder.
module bin2gray_comb
  import gray_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);
  assign gray = WIDTH'(bin2gray(16'(bin)));
endmodule

// File: rtl/gray_counter.sv
// Gray-code up/down counter with synchronous load and one-cycle wrap pulse.
// GRAY_COUNTER_SATURATE_EN: saturate at the limits instead of wrapping.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b_cnt,
  output logic             wrap
);
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] g_nxt;
  logic [WIDTH-1:0] step;
  logic             at_lim;
  logic             wrap_nxt;

  assign at_lim = up ? (&b_cnt) : (b_cnt == '0);
  assign step   = up ? (b_cnt + WIDTH'(1)) : (b_cnt - WIDTH'(1));

  always_comb begin
    cnt_nxt  = b_cnt;
    wrap_nxt = 1'b0;
    if (load) begin
      cnt_nxt = d;
    end else if (en) begin
      wrap_nxt = at_lim;
`ifdef GRAY_COUNTER_SATURATE_EN
      cnt_nxt  = at_lim ? b_cnt : step;
`else
      cnt_nxt  = step;
`endif
    end
  end

  // Encode the next-state value so g and b_cnt always agree in the same cycle.
  bin2gray_comb #(.WIDTH(WIDTH)) u_enc (
    .bin  (cnt_nxt),
    .gray (g_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_cnt <= '0;
      g     <= '0;
      wrap  <= 1'b0;
    end else begin
      b_cnt <= cnt_nxt;
      g     <= g_nxt;
      wrap  <= wrap_nxt;
    end
  end
endmodule
